// File: rtl/buffer_arbiter.sv
// rtl/buffer_arbiter.sv - two-requester arbiter for one single-port async-read Buffer
// Burst-limited round-robin; define BUF_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module buffer_arbiter #(
  parameter int WORD_SIZE   = 8,
  parameter int LENGTH_SIZE = 784,
  parameter int MAX_BURST   = 4,
  localparam int ADR_SIZE   = $clog2(LENGTH_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 wr0_i,
  input  logic                 wr1_i,
  input  logic [ADR_SIZE-1:0]  adr0_i,
  input  logic [ADR_SIZE-1:0]  adr1_i,
  input  logic [WORD_SIZE-1:0] dataIn0_i,
  input  logic [WORD_SIZE-1:0] dataIn1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 rdValid0_o,
  output logic                 rdValid1_o,
  output logic [WORD_SIZE-1:0] rdData0_o,
  output logic [WORD_SIZE-1:0] rdData1_o,
  output logic                 bufWr_o,
  output logic [ADR_SIZE-1:0]  bufAdr_o,
  output logic [WORD_SIZE-1:0] bufDataIn_o,
  input  logic [WORD_SIZE-1:0] bufDataOut_i
);

  logic                 rd_valid0_q, rd_valid1_q;
  logic [WORD_SIZE-1:0] rd_data0_q, rd_data1_q;

`ifdef BUF_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (rst_ni) begin
      gnt0_o = req0_i;
      gnt1_o = req1_i & ~req0_i;
    end
  end
`else
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;

  // On contention the owner keeps the port until it has used up its burst.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (rst_ni) begin
      if (req0_i && req1_i) begin
        if (cnt_q < MAX_CNT) begin
          gnt0_o = ~owner_q;
          gnt1_o = owner_q;
        end else begin
          gnt0_o = owner_q;
          gnt1_o = ~owner_q;
        end
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = 4'd0;
    if (gnt0_o || gnt1_o) begin
      if (gnt1_o == owner_q) begin
        cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 4'd1;
      end else begin
        owner_d = gnt1_o;
        cnt_d   = 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  always_comb begin
    bufWr_o     = 1'b0;
    bufAdr_o    = '0;
    bufDataIn_o = '0;
    if (gnt0_o) begin
      bufWr_o     = wr0_i;
      bufAdr_o    = adr0_i;
      bufDataIn_o = dataIn0_i;
    end else if (gnt1_o) begin
      bufWr_o     = wr1_i;
      bufAdr_o    = adr1_i;
      bufDataIn_o = dataIn1_i;
    end
  end

  // Buffer read is asynchronous, so the winner's data is captured at the grant edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
    end else begin
      rd_valid0_q <= gnt0_o & ~wr0_i;
      rd_valid1_q <= gnt1_o & ~wr1_i;
      if (gnt0_o && !wr0_i) rd_data0_q <= bufDataOut_i;
      if (gnt1_o && !wr1_i) rd_data1_q <= bufDataOut_i;
    end
  end

  assign rdValid0_o = rd_valid0_q;
  assign rdValid1_o = rd_valid1_q;
  assign rdData0_o  = rd_data0_q;
  assign rdData1_o  = rd_data1_q;

endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
- Shares one single-port Buffer instance (async read, write on clk rising edge) between two requesters, e.g. a conv-layer writer and a pool-layer reader.
- Each cycle, selects at most one requester and drives the Buffer's wr/adr/dataIn from the winner.
- Registers read data back to the winner with 1-cycle latency.
- Burst-limited round-robin arbitration on contention.

Parameters:
- WORD_SIZE, 8, data word width; must match the Buffer.
- LENGTH_SIZE, 784, Buffer depth in words (28x28 MNIST image); ADR_SIZE = $clog2(LENGTH_SIZE) is a localparam.
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0 / req1  in  1  requester 0/1 wants one access this cycle.
- wr0 / wr1  in  1  1 = write, 0 = read; sampled with reqN.
- adr0 / adr1  in  ADR_SIZE  access address.
- dataIn0 / dataIn1  in  WORD_SIZE  write data.
- gnt0 / gnt1  out  1  combinational; access accepted this cycle.
- rdValid0 / rdValid1  out  1  registered; one-cycle pulse, read data available.
- rdData0 / rdData1  out  WORD_SIZE  registered read data; holds until the next read by the same requester.
- bufWr  out  1  to Buffer wr.
- bufAdr  out  ADR_SIZE  to Buffer adr.
- bufDataIn  out  WORD_SIZE  to Buffer dataIn.
- bufDataOut  in  WORD_SIZE  from Buffer dataOut.

Behaviour:
- Reset: clk rising edge with rst_n=0.
  - owner=0, cnt=0, rdValid0/1=0, rdData0/1=0.
  - gnt0/1 and bufWr are 0 during reset regardless of req.
- Grant selection (combinational):
  - Neither req: no grant; bufWr=0, bufAdr=0, bufDataIn=0.
  - Exactly one req: that requester is granted.
  - Both req and cnt<MAX_BURST: owner is granted.
  - Both req and cnt==MAX_BURST: the non-owner is granted.
- Mux: bufWr = wr of winner; bufAdr/bufDataIn = winner's adr/dataIn.
- State update each clock:
  - Winner g == owner: cnt <= min(cnt+1, MAX_BURST).
  - Winner g != owner: owner <= g, cnt <= 1.
  - No grant: owner held, cnt <= 0.
  - cnt width is 4 bits.
- Read path:
  - Granted read (wrN=0): at the next edge, rdDataN <= bufDataOut and rdValidN <= 1 for exactly one cycle.
  - Granted write: rdValidN stays 0; the Buffer memory updates at the same edge.
  - Back-to-back reads by one requester give rdValid high on consecutive cycles.
- Hazards:
  - Read in cycle t+1 of an address written in cycle t, by either requester, returns the new data.
  - Read and write by different requesters in the same cycle are impossible; only one is granted.
- Requester contract:
  - reqN is a per-cycle request, not held state. An ungranted requester keeps req/wr/adr/dataIn stable until gnt.
  - The arbiter does not queue requests.
- Mid-operation reset: any pending rdValid is cleared; the access granted in the reset cycle is dropped (no Buffer write).
- Fairness: under continuous contention, grants alternate in runs of MAX_BURST (first run of requester 0 = MAX_BURST cycles).

Optional Feature:
- Macro: BUF_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention; requester 1 is granted only when req0=0. owner/cnt logic is not built and MAX_BURST is ignored.
- Undefined: burst-limited round-robin as above.
- The read path is identical in both modes.

Test Plan:
- Reset with req0=req1=1 held -> gnt0=gnt1=0, bufWr=0, rdValid0/1=0 during reset; after release, first grant goes to requester 0.
- Requester 0 writes 0xA5 to adr 10; next cycle requester 1 reads adr 10 -> gnt1=1, the cycle after rdValid1=1, rdData1=0xA5, rdValid0 stays 0.
- MAX_BURST=4, both requesting reads continuously for 12 cycles -> gnt pattern 0,0,0,0,1,1,1,1,0,0,0,0; rdValid follows one cycle later.
- Requester 1 alone for 6 cycles (adr 0..5 pre-loaded with 0..5) -> gnt1 every cycle, rdData1 = 0,1,2,3,4,5 on consecutive cycles, no burst cut.
- rst_n low during a granted write of 0xFF to adr 3 (adr 3 previously 0x11) -> read of adr 3 after reset returns 0x11.
- With BUF_ARB_FIXED_PRIO_EN, both requesting for 10 cycles -> gnt0=1 all cycles, gnt1=0; drop req0 -> gnt1=1 same cycle.
